plc_timebase: RTL and testbench

Free-running timebase for the ladder-logic fabric. Divides the FPGA system clock into the 1 kHz square-wave `tick` consumed by every timer element. It also provides a one-clock strobe per millisecond and a 32-bit millisecond counter. An optional scan watchdog flags a fault when the rung-scan engine stops reporting completed scans.

---
 rtl/plc_timebase.sv | 123 ++++++++++++
 tb/tb_plc_timebase.sv | 134 +++++++++++++
 2 files changed

// File: rtl/plc_timebase.sv
// plc_timebase: divides clk into the TICK_HZ square wave, a per-tick strobe and a
// millisecond counter; the scan watchdog is built only when PLC_TIMEBASE_WDT_EN is defined.
module plc_timebase #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned WDT_MS  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        clear,
    output logic        tick,
    output logic        tick_pulse,
    output logic [31:0] ms_count,
    input  logic        wdt_arm,
    input  logic        scan_done,
    input  logic        wdt_clear,
    output logic        wdt_fault
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_FALL = PW'(DIV / 2 - 1);

    logic [PW-1:0] pre;
    logic          wrap;

    assign wrap = run && pre == PRE_MAX;

    // prescaler, tick phase, strobe and elapsed-tick counter; tick rises on the wrap, falls half a period later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre        <= '0;
            tick       <= 1'b0;
            tick_pulse <= 1'b0;
            ms_count   <= '0;
        end else if (clear) begin
            pre        <= '0;
            tick       <= 1'b0;
            tick_pulse <= 1'b0;
            ms_count   <= '0;
        end else begin
            tick_pulse <= wrap;
            if (run)
                pre <= wrap ? '0 : pre + PW'(1);
            if (wrap) begin
                tick     <= 1'b1;
                ms_count <= ms_count + 32'd1;
            end else if (run && pre == PRE_FALL) begin
                tick <= 1'b0;
            end
        end
    end

`ifdef PLC_TIMEBASE_WDT_EN
    typedef enum logic [1:0] {IDLE, ARMED, FAULT} wdt_state_t;

    localparam logic [15:0] WDT_LIM = 16'(WDT_MS);

    wdt_state_t  state, state_n;
    logic [15:0] wcnt, wcnt_n;
    logic        fault_n;

    // watchdog state, scan-age counter and sticky fault registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            wdt_fault <= 1'b0;
        end else begin
            state     <= state_n;
            wcnt      <= wcnt_n;
            wdt_fault <= fault_n;
        end
    end

    // next state: scan_done beats a coincident tick so a scan finishing on the limit tick never faults
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        fault_n = wdt_fault;
        case (state)
            IDLE: begin
                wcnt_n = '0;
                if (wdt_arm)
                    state_n = ARMED;
            end
            ARMED: begin
                if (!wdt_arm) begin
                    state_n = IDLE;
                    wcnt_n  = '0;
                end else if (scan_done) begin
                    wcnt_n = '0;
                end else if (tick_pulse) begin
                    if (wcnt + 16'd1 == WDT_LIM) begin
                        state_n = FAULT;
                        fault_n = 1'b1;
                    end else begin
                        wcnt_n = wcnt + 16'd1;
                    end
                end
            end
            FAULT: begin
                if (wdt_clear) begin
                    state_n = IDLE;
                    wcnt_n  = '0;
                    fault_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                wcnt_n  = '0;
                fault_n = 1'b0;
            end
        endcase
    end
`else
    logic unused_wdt;

    assign unused_wdt = &{1'b0, wdt_arm, scan_done, wdt_clear, 16'(WDT_MS)};
    assign wdt_fault  = 1'b0;
`endif
endmodule

// File: tb/tb_plc_timebase.sv
// tb_plc_timebase: directed checks of plc_timebase with DIV=10 and WDT_MS=3.
module tb_plc_timebase;
`ifdef PLC_TIMEBASE_WDT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic        clk, rst, run, clear, wdt_arm, scan_done, wdt_clear;
    logic        tick, tick_pulse, wdt_fault;
    logic [31:0] ms_count;
    int          tests = 0;
    int          fails = 0;

    plc_timebase #(.CLK_HZ(10), .TICK_HZ(1), .WDT_MS(3)) dut (
        .clk(clk), .rst(rst), .run(run), .clear(clear),
        .tick(tick), .tick_pulse(tick_pulse), .ms_count(ms_count),
        .wdt_arm(wdt_arm), .scan_done(scan_done), .wdt_clear(wdt_clear),
        .wdt_fault(wdt_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // asynchronous reset: outputs must clear without a clock edge; the next posedge after release is edge 1
    task automatic reset_dut();
        rst = 1'b0;
        run = 1'b1;
        clear = 1'b0;
        wdt_arm = 1'b0;
        scan_done = 1'b0;
        wdt_clear = 1'b0;
        #2;
        check("reset tick", {31'b0, tick}, 32'd0);
        check("reset tick_pulse", {31'b0, tick_pulse}, 32'd0);
        check("reset ms_count", ms_count, 32'd0);
        check("reset wdt_fault", {31'b0, wdt_fault}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        reset_dut();
        for (int n = 1; n <= 35; n++) begin
            step();
            check("s1 tick_pulse", {31'b0, tick_pulse}, 32'(n % 10 == 0));
            check("s1 tick", {31'b0, tick}, 32'(n >= 10 && n % 10 < 5));
        end
        check("s1 ms_count", ms_count, 32'd3);

        reset_dut();
        for (int n = 1; n <= 30; n++) begin
            run = !(n >= 14 && n <= 20);
            step();
            check("s2 tick_pulse", {31'b0, tick_pulse}, 32'(n == 10 || n == 27));
            if (n >= 13 && n <= 26)
                check("s2 ms_count frozen", ms_count, 32'd1);
        end
        check("s2 ms_count resumed", ms_count, 32'd2);
        run = 1'b1;

        reset_dut();
        for (int n = 1; n <= 25; n++) begin
            clear = (n == 15);
            step();
            if (n == 15 || n == 16) begin
                check("s3 ms_count cleared", ms_count, 32'd0);
                check("s3 tick cleared", {31'b0, tick}, 32'd0);
            end
            check("s3 tick_pulse", {31'b0, tick_pulse}, 32'(n == 10 || n == 25));
        end
        clear = 1'b0;

        reset_dut();
        for (int n = 1; n <= 9; n++)
            step();
        force dut.ms_count = 32'hFFFF_FFFF;
        #1;
        release dut.ms_count;
        check("s4 ms_count preset", ms_count, 32'hFFFF_FFFF);
        step();
        check("s4 ms_count wrap", ms_count, 32'd0);
        check("s4 tick_pulse at wrap", {31'b0, tick_pulse}, 32'd1);

        reset_dut();
        wdt_arm = 1'b1;
        for (int n = 1; n <= 81; n++) begin
            scan_done = (n == 15 || n == 35 || n == 55);
            step();
            check("s5 wdt_fault", {31'b0, wdt_fault}, 32'(WDT && n == 81));
        end
        scan_done = 1'b0;
        wdt_arm = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            check("s5 fault held disarmed", {31'b0, wdt_fault}, 32'(WDT));
        end
        wdt_clear = 1'b1;
        step();
        wdt_clear = 1'b0;
        check("s5 fault cleared", {31'b0, wdt_fault}, 32'd0);

        reset_dut();
        wdt_arm = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            scan_done = (n == 31);
            step();
            check("s6 wdt_fault", {31'b0, wdt_fault}, 32'd0);
`ifdef PLC_TIMEBASE_WDT_EN
            if (n == 30)
                check("s6 wcnt before limit", {16'b0, dut.wcnt}, 32'd2);
            if (n == 31)
                check("s6 wcnt scan wins", {16'b0, dut.wcnt}, 32'd0);
`endif
        end
        scan_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
